// File: rtl/trigger_capture_buffer.sv
// Trigger capture buffer: circular pre/post-trigger sample recorder with
// oldest-first valid/ready readout and latched trigger timestamp/fields.
// Ports:
//   clk, rst                      clock, async active-high reset
//   arm, abort                    start capture (IDLE only) / return to IDLE
//   pre_count, post_count         window sizes, latched on arm
//   data_in, channel_in, data_valid     tagged sample stream
//   trigger_in, trigger_valid_in  trigger from the engine
//   trigger_confidence_in, trigger_metadata_in  trigger side data
//   out_data, out_valid, out_ready, out_last    readout stream
//   capture_done, state_out       status
//   trig_timestamp, trig_confidence, trig_metadata  latched trigger info
module trigger_capture_buffer #(
  parameter int DEPTH     = 256,
  parameter int ADC_WIDTH = 12,
  parameter int CH_WIDTH  = 4,
  parameter int TS_WIDTH  = 32,
  localparam int AW = $clog2(DEPTH),
  localparam int DW = CH_WIDTH + ADC_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 arm,
  input  logic                 abort,
  input  logic [AW-1:0]        pre_count,
  input  logic [AW:0]          post_count,
  input  logic [ADC_WIDTH-1:0] data_in,
  input  logic [CH_WIDTH-1:0]  channel_in,
  input  logic                 data_valid,
  input  logic                 trigger_in,
  input  logic                 trigger_valid_in,
  input  logic [7:0]           trigger_confidence_in,
  input  logic [15:0]          trigger_metadata_in,
  output logic [DW-1:0]        out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_last,
  output logic                 capture_done,
  output logic [1:0]           state_out,
  output logic [TS_WIDTH-1:0]  trig_timestamp,
  output logic [7:0]           trig_confidence,
  output logic [15:0]          trig_metadata
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    POST    = 2'd2,
    READOUT = 2'd3
  } state_t;

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_C   = (AW+1)'(1);

  state_t              state;
  logic [DW-1:0]       mem [DEPTH];
  logic [DW-1:0]       rd_word;
  logic [TS_WIDTH-1:0] ts;
  logic [AW-1:0]       pre;
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;
  logic [AW:0]         post;
  logic [AW:0]         fill;
  logic [AW:0]         remaining;
  logic [AW:0]         rd_left;
  logic [AW:0]         post_lim;
  logic [AW:0]         post_clamped;
  logic                accept;
  logic                wr_en;
  logic                rd_en;

  // pre_count is AW bits wide, so it never exceeds DEPTH-1; only post
  // needs clamping so that pre+post fits in the ring.
  always_comb begin
    post_lim     = DEPTH_C - {1'b0, pre_count};
    post_clamped = post_count;
    if (post_count == '0)
      post_clamped = ONE_C;
    else if (post_count > post_lim)
      post_clamped = post_lim;
  end

  // fill is the pre-write value, so the trigger-cycle sample is not
  // counted toward the pre-trigger history.
  assign accept = (state == ARMED) && trigger_in &&
                  trigger_valid_in && (fill >= {1'b0, pre});

  assign wr_en = !abort && data_valid &&
                 ((state == ARMED) || (state == POST));

  // Refill the output register whenever it is empty or being consumed.
  assign rd_en = !abort && (state == READOUT) && (rd_left != '0) &&
                 (!out_valid || out_ready);

  assign out_data  = out_valid ? rd_word : '0;
  assign state_out = state;

  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_ptr] <= {channel_in, data_in};
    if (rd_en)
      rd_word <= mem[rd_ptr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      ts              <= '0;
      pre             <= '0;
      post            <= '0;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      fill            <= '0;
      remaining       <= '0;
      rd_left         <= '0;
      out_valid       <= 1'b0;
      out_last        <= 1'b0;
      capture_done    <= 1'b0;
      trig_timestamp  <= '0;
      trig_confidence <= '0;
      trig_metadata   <= '0;
    end else begin
      ts           <= ts + TS_WIDTH'(1);
      capture_done <= 1'b0;
      if (abort) begin
        state     <= IDLE;
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (arm) begin
              pre    <= pre_count;
              post   <= post_clamped;
              wr_ptr <= '0;
              fill   <= '0;
              state  <= ARMED;
            end
          end
          ARMED: begin
            if (data_valid) begin
              wr_ptr <= wr_ptr + AW'(1);
              if (fill != DEPTH_C)
                fill <= fill + ONE_C;
            end
            if (accept) begin
              trig_timestamp  <= ts;
              trig_confidence <= trigger_confidence_in;
              trig_metadata   <= trigger_metadata_in;
              rd_ptr    <= wr_ptr - pre;
              rd_left   <= {1'b0, pre} + post;
              remaining <= post - {{AW{1'b0}}, data_valid};
              if (data_valid && (post == ONE_C)) begin
                state        <= READOUT;
                capture_done <= 1'b1;
              end else begin
                state <= POST;
              end
            end
          end
          POST: begin
            if (data_valid) begin
              wr_ptr    <= wr_ptr + AW'(1);
              remaining <= remaining - ONE_C;
              if (remaining == ONE_C) begin
                state        <= READOUT;
                capture_done <= 1'b1;
              end
            end
          end
          READOUT: begin
            if (rd_en) begin
              rd_ptr    <= rd_ptr + AW'(1);
              rd_left   <= rd_left - ONE_C;
              out_valid <= 1'b1;
              out_last  <= (rd_left == ONE_C);
            end else if (out_valid && out_ready) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              state     <= IDLE;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_trigger_capture_buffer.sv
// Bench for trigger_capture_buffer: a 256-deep and a 16-deep instance share
// stimulus; a queue model of the sample history predicts each window.
`timescale 1ns/1ps
module tb_trigger_capture_buffer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        arm = 1'b0;
  logic        abort = 1'b0;
  int          tb_pre = 0;
  int          tb_post = 0;
  logic [7:0]  pre_b;
  logic [8:0]  post_b;
  logic [3:0]  pre_s;
  logic [4:0]  post_s;
  logic [11:0] data_in = '0;
  logic [3:0]  channel_in = '0;
  logic        data_valid = 1'b0;
  logic        trigger_in = 1'b0;
  logic        trigger_valid_in = 1'b0;
  logic [7:0]  trigger_confidence_in = '0;
  logic [15:0] trigger_metadata_in = '0;
  logic        out_ready = 1'b0;

  logic [15:0] b_data, s_data, o_data;
  logic        b_ov, s_ov, o_ov;
  logic        b_last, s_last, o_last;
  logic        b_cd, s_cd, o_cd;
  logic [1:0]  b_state, s_state, o_state;
  logic [31:0] b_ts, s_ts, o_ts;
  logic [7:0]  b_conf, s_conf, o_conf;
  logic [15:0] b_meta, s_meta, o_meta;
  logic        sel = 1'b0;

  assign pre_b  = tb_pre[7:0];
  assign post_b = tb_post[8:0];
  assign pre_s  = tb_pre[3:0];
  assign post_s = tb_post[4:0];

  assign o_data  = sel ? s_data  : b_data;
  assign o_ov    = sel ? s_ov    : b_ov;
  assign o_last  = sel ? s_last  : b_last;
  assign o_cd    = sel ? s_cd    : b_cd;
  assign o_state = sel ? s_state : b_state;
  assign o_ts    = sel ? s_ts    : b_ts;
  assign o_conf  = sel ? s_conf  : b_conf;
  assign o_meta  = sel ? s_meta  : b_meta;

  trigger_capture_buffer #(.DEPTH(256)) u_big (
    .clk(clk), .rst(rst), .arm(arm), .abort(abort),
    .pre_count(pre_b), .post_count(post_b),
    .data_in(data_in), .channel_in(channel_in), .data_valid(data_valid),
    .trigger_in(trigger_in), .trigger_valid_in(trigger_valid_in),
    .trigger_confidence_in(trigger_confidence_in),
    .trigger_metadata_in(trigger_metadata_in),
    .out_data(b_data), .out_valid(b_ov), .out_ready(out_ready),
    .out_last(b_last), .capture_done(b_cd), .state_out(b_state),
    .trig_timestamp(b_ts), .trig_confidence(b_conf), .trig_metadata(b_meta)
  );

  trigger_capture_buffer #(.DEPTH(16)) u_small (
    .clk(clk), .rst(rst), .arm(arm), .abort(abort),
    .pre_count(pre_s), .post_count(post_s),
    .data_in(data_in), .channel_in(channel_in), .data_valid(data_valid),
    .trigger_in(trigger_in), .trigger_valid_in(trigger_valid_in),
    .trigger_confidence_in(trigger_confidence_in),
    .trigger_metadata_in(trigger_metadata_in),
    .out_data(s_data), .out_valid(s_ov), .out_ready(out_ready),
    .out_last(s_last), .capture_done(s_cd), .state_out(s_state),
    .trig_timestamp(s_ts), .trig_confidence(s_conf), .trig_metadata(s_meta)
  );

  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_fail = 0;
  int          cd_cnt = 0;
  logic [31:0] my_ts;
  int          m_st = 0;
  int          m_pre, m_post, m_left;
  logic [15:0] hist[$];
  logic [15:0] m_win[$];
  logic [31:0] e_ts;
  logic [7:0]  e_conf;
  logic [15:0] e_meta;

  // Cycle count since reset release: the value seen during a cycle.
  always @(posedge clk or posedge rst)
    if (rst) my_ts <= '0;
    else     my_ts <= my_ts + 32'd1;

  always @(negedge clk)
    if (o_cd === 1'b1) cd_cnt++;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic sync_idle();
    arm = 1'b0; data_valid = 1'b0; trigger_in = 1'b0;
    abort = 1'b1;
    step();
    abort = 1'b0;
    m_st = 0;
  endtask

  task automatic do_arm(input int p, input int q);
    int d, qq;
    d = sel ? 16 : 256;
    tb_pre = p; tb_post = q;
    m_pre = p % d;
    qq = q % (2 * d);
    m_post = (qq == 0) ? 1 : ((qq > d - m_pre) ? d - m_pre : qq);
    data_valid = 1'b0; trigger_in = 1'b0;
    arm = 1'b1;
    step();
    arm = 1'b0;
    hist.delete(); m_win.delete();
    m_st = 1; cd_cnt = 0;
  endtask

  task automatic feed(input logic dv, input logic [11:0] d,
                      input logic [3:0] ch, input logic tg, input logic tv);
    logic [15:0] w;
    data_valid = dv; data_in = d; channel_in = ch;
    trigger_in = tg; trigger_valid_in = tv;
    trigger_confidence_in = 8'($urandom);
    trigger_metadata_in = 16'($urandom);
    w = {ch, d};
    if (m_st == 1 && tg && tv && hist.size() >= m_pre) begin
      m_win.delete();
      for (int i = hist.size() - m_pre; i < hist.size(); i++)
        m_win.push_back(hist[i]);
      m_left = m_post; m_st = 2;
      e_ts = my_ts; e_conf = trigger_confidence_in;
      e_meta = trigger_metadata_in;
    end
    if (dv && m_st == 2) begin
      m_win.push_back(w);
      m_left--;
      if (m_left == 0) m_st = 3;
    end else if (dv && m_st == 1) begin
      hist.push_back(w);
      if (hist.size() > 256) void'(hist.pop_front());
    end
    step();
  endtask

  task automatic collect(input string nm, input int mode, input int arm_at);
    int idx, n, first_hs, last_hs;
    logic stalled, held_l;
    logic [15:0] held_d;
    idx = 0; n = m_win.size(); first_hs = -1; last_hs = -1;
    stalled = 1'b0; held_l = 1'b0; held_d = '0;
    n_chk++;
    if (o_cd !== 1'b1 || o_ov !== 1'b0) begin
      n_fail++;
      $display("FAIL %s entry: capture_done=%b out_valid=%b required 1 0",
               nm, o_cd, o_ov);
    end
    for (int cyc = 0; cyc < 2000 && idx < n; cyc++) begin
      case (mode)
        1: out_ready = 1'b1;
        2: out_ready = (cyc % 2 == 0);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      data_valid = 1'($urandom_range(0, 1));
      data_in = 12'($urandom); channel_in = 4'($urandom);
      trigger_in = 1'($urandom_range(0, 1)); trigger_valid_in = 1'b1;
      arm = (cyc == arm_at);
      if (stalled) begin
        n_chk++;
        if (o_ov !== 1'b1 || o_data !== held_d || o_last !== held_l) begin
          n_fail++;
          $display("FAIL %s hold: valid=%b data=%h last=%b required 1 %h %b",
                   nm, o_ov, o_data, o_last, held_d, held_l);
        end
      end
      if (o_ov === 1'b1 && out_ready) begin
        n_chk++;
        if (o_data !== m_win[idx]) begin
          n_fail++;
          $display("FAIL %s word%0d: got %h required %h",
                   nm, idx, o_data, m_win[idx]);
        end
        n_chk++;
        if (o_last !== (idx == n - 1)) begin
          n_fail++;
          $display("FAIL %s last%0d: got %b required %b",
                   nm, idx, o_last, (idx == n - 1));
        end
        if (first_hs < 0) first_hs = cyc;
        last_hs = cyc;
        idx++;
        stalled = 1'b0;
      end else begin
        stalled = (o_ov === 1'b1);
        held_d = o_data; held_l = o_last;
      end
      step();
    end
    arm = 1'b0; data_valid = 1'b0; trigger_in = 1'b0;
    n_chk++;
    if (idx != n) begin
      n_fail++;
      $display("FAIL %s count: got %0d words required %0d", nm, idx, n);
    end
    n_chk++;
    if (o_ov !== 1'b0 || o_state !== 2'd0) begin
      n_fail++;
      $display("FAIL %s end: valid=%b state=%0d required 0 0",
               nm, o_ov, o_state);
    end
    if (mode == 1) begin
      n_chk++;
      if (first_hs != 1 || last_hs != n) begin
        n_fail++;
        $display("FAIL %s timing: first=%0d last=%0d required 1 %0d",
                 nm, first_hs, last_hs, n);
      end
    end
  endtask

  task automatic check_trig(input string nm);
    n_chk++;
    if (o_ts !== e_ts || o_conf !== e_conf || o_meta !== e_meta) begin
      n_fail++;
      $display("FAIL %s trig: ts=%0d conf=%h meta=%h required %0d %h %h",
               nm, o_ts, o_conf, o_meta, e_ts, e_conf, e_meta);
    end
  endtask

  task automatic test_reset();
    n_chk++;
    if (o_state !== 2'd0 || o_ov !== 1'b0 || o_last !== 1'b0 ||
        o_cd !== 1'b0 || o_data !== 16'h0) begin
      n_fail++;
      $display("FAIL reset outs: state=%0d v=%b l=%b cd=%b d=%h required 0",
               o_state, o_ov, o_last, o_cd, o_data);
    end
    n_chk++;
    if (o_ts !== 32'h0 || o_conf !== 8'h0 || o_meta !== 16'h0) begin
      n_fail++;
      $display("FAIL reset trig: ts=%h conf=%h meta=%h required 0",
               o_ts, o_conf, o_meta);
    end
    n_chk++;
    if (s_state !== 2'd0 || s_ov !== 1'b0) begin
      n_fail++;
      $display("FAIL reset small: state=%0d v=%b required 0", s_state, s_ov);
    end
  endtask

  task automatic test_basic();
    sel = 1'b0; sync_idle(); do_arm(4, 4);
    for (int i = 0; i < 20 && m_st != 3; i++)
      feed(1'b1, 12'(i), 4'd1, i == 10, 1'b1);
    collect("basic", 1, -1);
    check_trig("basic");
    n_chk++;
    if (cd_cnt != 1) begin
      n_fail++;
      $display("FAIL basic capture_done: pulses %0d required 1", cd_cnt);
    end
  endtask

  task automatic test_prefill();
    sel = 1'b0; sync_idle(); do_arm(8, 2);
    for (int i = 0; i < 30 && m_st != 3; i++) begin
      feed(1'b1, 12'(i), 4'd1, i == 2 || i == 9, 1'b1);
      if (i == 2) begin
        n_chk++;
        if (o_state !== 2'd1) begin
          n_fail++;
          $display("FAIL prefill gate: state=%0d required 1", o_state);
        end
      end
    end
    collect("prefill", 3, -1);
    check_trig("prefill");
  endtask

  task automatic test_wrap();
    sel = 1'b1; sync_idle(); do_arm(12, 4);
    for (int i = 0; i < 50 && m_st != 3; i++)
      feed(1'b1, 12'(i), 4'd2, i == 40, 1'b1);
    collect("wrap", 1, -1);
    check_trig("wrap");
    sel = 1'b0;
  endtask

  task automatic test_backpressure();
    sel = 1'b0; sync_idle(); do_arm(4, 4);
    for (int i = 0; i < 30 && m_st != 3; i++)
      feed(1'b1, 12'($urandom), 4'($urandom), i == 9, 1'b1);
    collect("bp", 2, -1);
  endtask

  task automatic test_abort();
    logic bad;
    sel = 1'b0; sync_idle();
    arm = 1'b1; abort = 1'b1;
    step();
    arm = 1'b0; abort = 1'b0;
    n_chk++;
    if (o_state !== 2'd0) begin
      n_fail++;
      $display("FAIL arm+abort: state=%0d required 0", o_state);
    end
    do_arm(4, 4);
    for (int i = 0; i < 6; i++)
      feed(1'b1, 12'(i), 4'd3, i == 5, 1'b1);
    n_chk++;
    if (o_state !== 2'd2) begin
      n_fail++;
      $display("FAIL abort setup: state=%0d required 2", o_state);
    end
    abort = 1'b1; data_valid = 1'b0; trigger_in = 1'b0;
    step();
    abort = 1'b0; m_st = 0;
    n_chk++;
    if (o_state !== 2'd0) begin
      n_fail++;
      $display("FAIL abort state: state=%0d required 0", o_state);
    end
    bad = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      feed(1'b1, 12'(i), 4'd3, 1'b1, 1'b1);
      if (o_ov !== 1'b0 || o_cd !== 1'b0) bad = 1'b1;
    end
    n_chk++;
    if (bad !== 1'b0) begin
      n_fail++;
      $display("FAIL abort quiet: valid/done seen %b required 0", bad);
    end
    check_trig("abort");
  endtask

  task automatic test_arm_in_readout();
    sel = 1'b0; sync_idle(); do_arm(2, 5);
    for (int i = 0; i < 20 && m_st != 3; i++)
      feed(1'b1, 12'(100 + i), 4'd4, i == 3, 1'b1);
    collect("armro", 1, 3);
  endtask

  task automatic test_post_zero();
    sel = 1'b0; sync_idle(); do_arm(3, 0);
    for (int i = 0; i < 20 && m_st != 3; i++)
      feed(1'b1, 12'(200 + i), 4'd5, i == 5, 1'b1);
    collect("post0", 1, -1);
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      int p, q, cyc;
      sel = it[0];
      sync_idle();
      p = sel ? $urandom_range(0, 15) : $urandom_range(0, 60);
      q = sel ? $urandom_range(0, 31) : $urandom_range(0, 80);
      do_arm(p, q);
      cyc = 0;
      while (m_st != 3 && cyc < 3000) begin
        feed($urandom_range(0, 3) != 0, 12'($urandom), 4'($urandom),
             $urandom_range(0, 7) == 0, $urandom_range(0, 4) != 0);
        cyc++;
      end
      n_chk++;
      if (m_st != 3) begin
        n_fail++;
        $display("FAIL random%0d capture: no capture in %0d cycles", it, cyc);
      end else begin
        collect("random", 3, -1);
        check_trig("random");
      end
    end
    sel = 1'b0;
  endtask

  task automatic test_reset_mid();
    sel = 1'b0; sync_idle(); do_arm(2, 2);
    for (int i = 0; i < 20 && m_st != 3; i++)
      feed(1'b1, 12'(i), 4'd6, i == 4, 1'b1);
    out_ready = 1'b0; data_valid = 1'b0; trigger_in = 1'b0;
    step(); step();
    n_chk++;
    if (o_ov !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid setup: valid=%b required 1", o_ov);
    end
    #2 rst = 1'b1;
    #1;
    n_chk++;
    if (o_ov !== 1'b0 || o_cd !== 1'b0 || o_state !== 2'd0 ||
        o_ts !== 32'h0 || o_conf !== 8'h0 || o_meta !== 16'h0) begin
      n_fail++;
      $display("FAIL rstmid: v=%b cd=%b st=%0d ts=%h c=%h m=%h required 0",
               o_ov, o_cd, o_state, o_ts, o_conf, o_meta);
    end
    @(negedge clk);
    rst = 1'b0; m_st = 0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_basic();
    test_prefill();
    test_wrap();
    test_backpressure();
    test_abort();
    test_arm_in_readout();
    test_post_zero();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/trigger_capture_buffer.md
Name: trigger_capture_buffer

Overview:
- Sits directly downstream of derivative_threshold_engine.
- Continuously records the tagged ADC sample stream into a circular buffer while armed.
- On an accepted trigger, it keeps a configurable pre-trigger history, then collects a configurable number of post-trigger samples.
- It then streams the captured window oldest-first over a valid/ready port, with the trigger's confidence, metadata and timestamp latched alongside.

Parameters:
- DEPTH, 256, buffer entries; power of 2, ≥ 4.
- ADC_WIDTH, 12, sample width.
- CH_WIDTH, 4, channel tag width.
- TS_WIDTH, 32, timestamp counter width.
- Derived: AW = log2(DEPTH).

Ports:
- clk  in  1  Single clock for the whole block.
- rst  in  1  Asynchronous, active-high reset.
- arm  in  1  Single-cycle pulse; honoured only in IDLE.
- abort  in  1  Returns the block to IDLE from any state.
- pre_count  in  AW  Pre-trigger samples, latched on arm.
- post_count  in  AW+1  Post-trigger samples including the trigger sample, latched on arm.
- data_in  in  ADC_WIDTH  Sample.
- channel_in  in  CH_WIDTH  Sample channel tag.
- data_valid  in  1  Sample qualifier.
- trigger_in  in  1  Trigger from the engine.
- trigger_valid_in  in  1  Trigger qualifier.
- trigger_confidence_in  in  8  Engine confidence.
- trigger_metadata_in  in  16  Engine metadata.
- out_data  out  CH_WIDTH+ADC_WIDTH  {channel, sample}.
- out_valid  out  1  Readout word valid.
- out_ready  in  1  Consumer ready.
- out_last  out  1  Final word of the window.
- capture_done  out  1  One-cycle pulse on entry to READOUT.
- state_out  out  2  IDLE=0, ARMED=1, POST=2, READOUT=3.
- trig_timestamp  out  TS_WIDTH  Timestamp counter value in the accepted trigger cycle.
- trig_confidence  out  8  Latched confidence of the accepted trigger.
- trig_metadata  out  16  Latched metadata of the accepted trigger.

Behaviour:
- Reset (asynchronous, immediate):
  - state IDLE.
  - All outputs 0.
  - Pointers, counters and timestamp cleared.
  - Buffer contents are don't-care.
  - Reset mid-operation discards the capture.
- Timestamp counter increments every cycle and wraps at 2^TS_WIDTH.
- Stored word is {channel_in, data_in}.
- Latching on arm (IDLE → ARMED):
  - pre = min(pre_count, DEPTH-1).
  - post = clamp(post_count, 1, DEPTH-pre).
  - wr_ptr = 0, fill = 0.
  - arm outside IDLE is ignored.
- ARMED:
  - Each data_valid writes at wr_ptr; wr_ptr increments mod DEPTH.
  - fill increments and saturates at DEPTH.
- Trigger acceptance:
  - A trigger is accepted when trigger_in && trigger_valid_in && fill ≥ pre, with fill sampled before that cycle's write.
  - Triggers before pre-fill completes are ignored silently.
- On an accepted trigger:
  - Latch trig_timestamp, trig_confidence and trig_metadata.
  - start_ptr = (wr_ptr_before_write - pre) mod DEPTH.
  - If data_valid is high in the same cycle, that sample is written and counts as post sample #1.
  - remaining = post - data_valid.
  - If remaining == 0, go to READOUT; otherwise go to POST.
- POST:
  - Each data_valid writes and decrements remaining.
  - When remaining reaches 0, go to READOUT.
  - trigger_in is ignored; the latched trigger values are not overwritten.
- capture_done is high for exactly the first cycle in READOUT.
- READOUT:
  - Emits pre+post words from start_ptr, wrapping mod DEPTH.
  - Input samples are ignored.
  - out_valid first rises the cycle after capture_done.
  - Synchronous-read RAM with a prefetch register sustains 1 word/cycle while out_ready is held high.
  - While out_valid && !out_ready, out_data and out_last are held stable.
  - out_last is high only with the final word.
  - After the final handshake: out_valid = 0 next cycle, state IDLE.
- Trigger fields hold their values until the next accepted trigger or reset.
- abort:
  - Takes effect at the next edge: state IDLE, out_valid = 0, out_last = 0, no capture_done.
  - abort has priority over arm and trigger in the same cycle.
- Simultaneous arm + abort in IDLE: stay in IDLE.

Test Plan:
- DEPTH=256, pre=4, post=4; arm, feed ch1 data_in = 0..19 one per cycle, trigger with sample 10 → capture_done once, readout 6,7,8,9,10,11,12,13 tagged ch1, out_last only on 13, trig_timestamp equals the counter value in the trigger cycle.
- Pre-fill gate, pre=8, post=2: trigger on 3rd sample → ignored, state_out stays 1; trigger on 10th sample (data 9) → readout 1..10.
- Wrap, DEPTH=16, pre=12, post=4: 40 samples (0..39) before trigger on sample 40 → 16 words 28..43 in order, no corruption across wrap.
- Backpressure: window of 8 with out_ready = 1,0,1,0... → each word seen once, stable while stalled, 8 handshakes; with out_ready held 1 → 8 consecutive-cycle words.
- abort during POST → state_out = 0 next cycle, out_valid never asserts. arm pulsed during READOUT → ignored, readout completes. post_count=0 → clamped to 1, window = pre+1 words.
- rst asserted mid-READOUT between clock edges → out_valid, capture_done, state_out and trig_* go to 0 immediately, before the next edge.
